// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and types for the 4-bit PRBS (x^4+x^3+1) generator/checker pair.
//   LFSR_W       history/shift-register width
//   TAP_A/TAP_B  feedback taps: the next bit is hist[TAP_A] ^ hist[TAP_B]
//   chk_state_t  checker FSM states
package lfsr_pkg;

    localparam int LFSR_W = 4;
    localparam int TAP_A  = 4;
    localparam int TAP_B  = 3;

    typedef enum logic [1:0] {
        SEED,
        HUNT,
        LOCKED
    } chk_state_t;

endpackage

// File: rtl/prbs_checker_if.sv
// prbs_checker_if: serial-bit and status bundle between a PRBS source and prbs_checker.
//   en         bit_in valid this cycle
//   bit_in     serial PRBS bit
//   clear_err  synchronous clear of the error counter
//   locked     checker is locked to the stream
//   bit_err    one-cycle pulse per mispredicted bit while locked
//   err_count  saturating error count (ERR_W bits)
// master = stream source / status consumer, slave = the checker.
interface prbs_checker_if #(
    parameter int ERR_W = 16
) ();

    logic             en;
    logic             bit_in;
    logic             clear_err;
    logic             locked;
    logic             bit_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output en, bit_in, clear_err,
        input  locked, bit_err, err_count
    );

    modport slave (
        input  en, bit_in, clear_err,
        output locked, bit_err, err_count
    );

endinterface

// File: rtl/prbs_predictor.sv
// prbs_predictor: 4-bit history register and next-bit predictor.
//   clk, rst   clock, async active-high reset (history cleared)
//   shift_en   shift one bit into the history this cycle
//   load_sel   0: shift in the received bit_in, 1: shift in pred (flywheel)
//   bit_in     received serial bit
//   pred       prediction for the bit about to arrive
//   hist_zero  history is all zeros (LFSR lock-up pattern)
module prbs_predictor
    import lfsr_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic load_sel,
    input  logic bit_in,
    output logic pred,
    output logic hist_zero
);

    // hist[1] is the newest bit, hist[LFSR_W] the oldest
    logic [LFSR_W:1] hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hist <= '0;
        else if (shift_en)
            hist <= {hist[LFSR_W-1:1], (load_sel ? pred : bit_in)};
    end

    assign pred      = hist[TAP_A] ^ hist[TAP_B];
    assign hist_zero = (hist == '0);

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for the x^4+x^3+1 PRBS bitstream.
//   clk        clock, all state on posedge
//   rst        asynchronous active-high reset
//   bus        prbs_checker_if.slave: en, bit_in, clear_err in; locked, bit_err, err_count out
// Flow: SEED loads 4 bits into the history, HUNT waits for LOCK_CNT consecutive correct
// predictions, LOCKED free-runs the predictor and counts mispredictions; LOSS_CNT
// consecutive misses drop back to SEED. All outputs are registered.
module prbs_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic            clk,
    input  logic            rst,
    prbs_checker_if.slave   bus
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    chk_state_t       state, state_nx;
    logic [1:0]       fill_cnt, fill_nx;
    logic [MW-1:0]    match_cnt, match_nx;
    logic [LW-1:0]    miss_cnt, miss_nx;
    logic             locked_q, locked_nx;
    logic             bit_err_q, bit_err_nx;
    logic [ERR_W-1:0] err_q;
    logic             err_inc;
    logic             shift_en, load_sel;
    logic             pred, hist_zero;

    prbs_predictor u_pred (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .load_sel  (load_sel),
        .bit_in    (bus.bit_in),
        .pred      (pred),
        .hist_zero (hist_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEED;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked_q  <= 1'b0;
            bit_err_q <= 1'b0;
        end else begin
            state     <= state_nx;
            fill_cnt  <= fill_nx;
            match_cnt <= match_nx;
            miss_cnt  <= miss_nx;
            locked_q  <= locked_nx;
            bit_err_q <= bit_err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        fill_nx    = fill_cnt;
        match_nx   = match_cnt;
        miss_nx    = miss_cnt;
        locked_nx  = locked_q;
        bit_err_nx = 1'b0;
        err_inc    = 1'b0;
        shift_en   = 1'b0;
        load_sel   = 1'b0;
        if (bus.en) begin
            shift_en = 1'b1;
            unique case (state)
                SEED: begin
                    fill_nx = fill_cnt + 2'd1;
                    if (fill_cnt == 2'd3) begin
                        state_nx = HUNT;
                        fill_nx  = 2'd0;
                    end
                end
                HUNT: begin
                    // an all-zero history predicts zeros forever; never treat it as a match
                    if (!hist_zero && (bus.bit_in == pred)) begin
                        if (match_cnt == MW'(LOCK_CNT - 1)) begin
                            state_nx  = LOCKED;
                            locked_nx = 1'b1;
                            match_nx  = '0;
                        end else begin
                            match_nx = match_cnt + MW'(1);
                        end
                    end else begin
                        match_nx = '0;
                    end
                end
                LOCKED: begin
                    // flywheel: history follows the prediction so one bad bit is one error
                    load_sel = 1'b1;
                    if (bus.bit_in != pred) begin
                        bit_err_nx = 1'b1;
                        err_inc    = 1'b1;
                        if (miss_cnt == LW'(LOSS_CNT - 1)) begin
                            state_nx  = SEED;
                            locked_nx = 1'b0;
                            fill_nx   = 2'd0;
                            miss_nx   = '0;
                        end else begin
                            miss_nx = miss_cnt + LW'(1);
                        end
                    end else begin
                        miss_nx = '0;
                    end
                end
                default: state_nx = SEED;
            endcase
        end
    end

    // clear wins over a same-cycle increment; saturated value holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= '0;
        else if (bus.clear_err)
            err_q <= '0;
        else if (err_inc && (err_q != {ERR_W{1'b1}}))
            err_q <= err_q + ERR_W'(1);
    end

    assign bus.locked    = locked_q;
    assign bus.bit_err   = bit_err_q;
    assign bus.err_count = err_q;

endmodule
